// File: rtl/uart_boot_loader_if.sv
// rtl/uart_boot_loader_if.sv - byte stream and memory write port of the boot loader
// master is the loader side; slave is the UART receiver plus memory side.
interface uart_boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic        rx_data_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_ack;

  modport master (
    input  rx_data, rx_data_valid, mem_ack,
    output rx_data_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output rx_data, rx_data_valid, mem_ack,
    input  rx_data_ready, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - UART boot frame decoder and memory writer
// Decodes SYNC,CMD,A0..A3,D0..D3,CSUM frames into word writes and a sticky boot release.
module uart_boot_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h55,
  parameter logic [7:0]  CMD_WRITE      = 8'h01,
  parameter logic [7:0]  CMD_RUN        = 8'h02,
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 270000
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_boot_loader_if.master bus,
  output logic               boot_done_o,
  output logic [7:0]         err_cnt_o
);
  localparam int unsigned       IDLE_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              mem_we_q, mem_we_d;
  logic              boot_done_q, boot_done_d;

  logic rx_ready;
  logic accept;
  logic in_frame;
  logic csum_ok;
  logic addr_ok;
  logic timeout;
  logic err_inc;

  // Ready is gated by reset so the receiver sees 0 while the block is held in reset.
  assign rx_ready = rst_n && (state_q != S_WRITE);
  assign accept   = bus.rx_data_valid && rx_ready;
  assign in_frame = state_q inside {S_CMD, S_ADDR, S_DATA, S_CSUM};
  assign csum_ok  = (bus.rx_data == csum_q);
  assign addr_ok  = (addr_q[1:0] == 2'b00) && ({2'b00, addr_q[31:2]} < MEM_WORDS);
  assign timeout  = in_frame && !accept && (idle_q == IDLE_LAST);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    csum_d      = csum_q;
    addr_d      = addr_q;
    data_d      = data_q;
    bcnt_d      = bcnt_q;
    idle_d      = idle_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    boot_done_d = boot_done_q;
    err_inc     = 1'b0;

    if (in_frame) begin
      idle_d = accept ? '0 : idle_q + IDLE_W'(1);
    end

    case (state_q)
      S_SYNC: begin
        if (accept && (bus.rx_data == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (accept) begin
          cmd_d   = bus.rx_data;
          csum_d  = bus.rx_data;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (accept) begin
          addr_d = {bus.rx_data, addr_q[31:8]};
          csum_d = csum_q ^ bus.rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d = {bus.rx_data, data_q[31:8]};
          csum_d = csum_q ^ bus.rx_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (csum_ok && (cmd_q == CMD_WRITE) && addr_ok) begin
            mem_addr_d  = addr_q;
            mem_wdata_d = data_q;
            mem_we_d    = 1'b1;
            state_d     = S_WRITE;
          end else if (csum_ok && (cmd_q == CMD_RUN)) begin
            boot_done_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            err_inc = 1'b1;
            state_d = S_SYNC;
          end
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          mem_we_d = 1'b0;
          state_d  = S_SYNC;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_SYNC;
      end
    endcase

    // A byte accepted on the expiry cycle already cleared the condition above.
    if (timeout) begin
      err_inc = 1'b1;
      state_d = S_SYNC;
    end

    if (state_d == S_SYNC) begin
      csum_d = '0;
      bcnt_d = '0;
      idle_d = '0;
    end

    err_cnt_d = (err_inc && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SYNC;
      cmd_q       <= '0;
      csum_q      <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      bcnt_q      <= '0;
      idle_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      boot_done_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      csum_q      <= csum_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      bcnt_q      <= bcnt_d;
      idle_q      <= idle_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      boot_done_q <= boot_done_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.rx_data_ready = rx_ready;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_we        = mem_we_q;
  assign boot_done_o       = boot_done_q;
  assign err_cnt_o         = err_cnt_q;
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb/tb_uart_boot_loader.sv - self-checking bench for uart_boot_loader
// Frame table plus hand sequences; a memory responder checks writes against a scoreboard queue.
module tb_uart_boot_loader;
  localparam int TO = 64;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
    bit          bad_csum;
    bit          exp_write;
    int          exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       boot_done;
  logic [7:0] err_cnt;

  wr_t sb_q[$];
  int  n_chk = 0;
  int  n_err = 0;
  int  ack_delay = 1;
  int  exp_err = 0;

  uart_boot_loader_if bus ();

  uart_boot_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .boot_done_o (boot_done),
    .err_cnt_o   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_data       = b;
    bus.rx_data_valid = 1'b1;
    while (!bus.rx_data_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_err++;
      $display("FAIL rx_ready_wait: ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d,
                            input bit bad);
    logic [7:0] b[9];
    logic [7:0] cs;
    b[0] = cmd;
    for (int i = 0; i < 4; i++) begin
      b[1+i] = a[8*i +: 8];
      b[5+i] = d[8*i +: 8];
    end
    cs = 8'h00;
    for (int i = 0; i < 9; i++) cs ^= b[i];
    send_byte(8'h55);
    for (int i = 0; i < 9; i++) send_byte(b[i]);
    send_byte(bad ? (cs ^ 8'h01) : cs);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(bus.rx_data_ready && !bus.mem_we) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_idle: loader busy for %0d cycles, required idle", n);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb_q.push_back(w);
  endtask

  initial begin : mem_responder
    wr_t exp;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_we) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write",
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          exp = sb_q.pop_front();
          chk("wr_addr", bus.mem_addr, exp.addr);
          chk("wr_data", bus.mem_wdata, exp.data);
        end
        for (int i = 0; i < ack_delay; i++) begin
          @(negedge clk);
          if (!rst_n) break;
          chk("hold_we", bus.mem_we, 1);
          chk("hold_ready", bus.rx_data_ready, 0);
          chk("hold_addr", bus.mem_addr, exp.addr);
        end
        if (rst_n) begin
          bus.mem_ack = 1'b1;
          @(negedge clk);
          bus.mem_ack = 1'b0;
          if (rst_n) chk("we_after_ack", bus.mem_we, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t       vec[10];
    logic [7:0] raw[$];

    vec[0] = '{8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 0};
    vec[1] = '{8'h01, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1};
    vec[2] = '{8'h01, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1, 0};
    vec[3] = '{8'h01, 32'h0000_0FFC, 32'hA5A5_A5A5, 1'b0, 1'b1, 0};
    vec[4] = '{8'h01, 32'h0000_1000, 32'h1111_1111, 1'b0, 1'b0, 1};
    vec[5] = '{8'h01, 32'h0000_0012, 32'h2222_2222, 1'b0, 1'b0, 1};
    vec[6] = '{8'h01, 32'h8000_0010, 32'h3333_3333, 1'b0, 1'b0, 1};
    vec[7] = '{8'h03, 32'h0000_0020, 32'h4444_4444, 1'b0, 1'b0, 1};
    vec[8] = '{8'h01, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1, 0};
    vec[9] = '{8'h02, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1};

    bus.rx_data       = 8'h00;
    bus.rx_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", bus.rx_data_ready, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_boot_done", boot_done, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("sync_ready", bus.rx_data_ready, 1);

    ack_delay = 2;
    foreach (vec[i]) begin
      if (vec[i].exp_write) push_wr(vec[i].addr, vec[i].data);
      send_frame(vec[i].cmd, vec[i].addr, vec[i].data, vec[i].bad_csum);
      exp_err += vec[i].exp_err;
      chk($sformatf("vec%0d_we", i), bus.mem_we, vec[i].exp_write);
      chk($sformatf("vec%0d_err", i), err_cnt, exp_err);
      chk($sformatf("vec%0d_boot", i), boot_done, 0);
      wait_idle();
    end
    chk("vec_sb_empty", sb_q.size(), 0);

    // Literal frame; its checksum is the XOR of CMD..D3 = 0x33. Ack held off for 5 cycles.
    ack_delay = 5;
    push_wr(32'h10, 32'hDEAD_BEEF);
    raw = '{8'h55, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
    foreach (raw[i]) send_byte(raw[i]);
    chk("t1_we", bus.mem_we, 1);
    wait_idle();
    ack_delay = 1;

    raw = '{8'h55, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4F};
    foreach (raw[i]) send_byte(raw[i]);
    exp_err++;
    chk("t2_we", bus.mem_we, 0);
    chk("t2_err", err_cnt, exp_err);
    push_wr(32'h14, 32'hCAFE_F00D);
    send_frame(8'h01, 32'h14, 32'hCAFE_F00D, 1'b0);
    chk("t2_recover_we", bus.mem_we, 1);
    wait_idle();

    push_wr(32'h10, 32'hDEAD_BEEF);
    raw = '{8'h00, 8'hFF, 8'h55, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
    foreach (raw[i]) send_byte(raw[i]);
    chk("t3_we", bus.mem_we, 1);
    chk("t3_err", err_cnt, exp_err);
    wait_idle();

    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h10);
    repeat (TO) @(posedge clk);
    #1;
    exp_err++;
    chk("t4_timeout_err", err_cnt, exp_err);
    chk("t4_timeout_ready", bus.rx_data_ready, 1);
    push_wr(32'h20, 32'h0BAD_F00D);
    send_frame(8'h01, 32'h20, 32'h0BAD_F00D, 1'b0);
    chk("t4_fresh_we", bus.mem_we, 1);
    wait_idle();

    // Stall one cycle short of the limit, then the next byte lands on the expiry edge.
    push_wr(32'h10, 32'hDEAD_BEEF);
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h10);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("t4_edge_no_timeout", err_cnt, exp_err);
    raw = '{8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33};
    foreach (raw[i]) send_byte(raw[i]);
    chk("t4_edge_we", bus.mem_we, 1);
    chk("t4_edge_err", err_cnt, exp_err);
    wait_idle();

    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h40);
    #2 rst_n = 1'b0;
    #1;
    exp_err = 0;
    chk("rst_frame_ready", bus.rx_data_ready, 0);
    chk("rst_frame_err", err_cnt, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    push_wr(32'h24, 32'h5555_AAAA);
    send_frame(8'h01, 32'h24, 32'h5555_AAAA, 1'b0);
    chk("rst_frame_we", bus.mem_we, 1);
    wait_idle();

    ack_delay = 20;
    push_wr(32'h28, 32'h7777_8888);
    send_frame(8'h01, 32'h28, 32'h7777_8888, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_write_we", bus.mem_we, 0);
    chk("rst_write_addr", bus.mem_addr, 0);
    chk("rst_write_wdata", bus.mem_wdata, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    ack_delay = 1;
    push_wr(32'h2C, 32'h9999_0000);
    send_frame(8'h01, 32'h2C, 32'h9999_0000, 1'b0);
    chk("rst_write_recover_we", bus.mem_we, 1);
    wait_idle();
    chk("hand_sb_empty", sb_q.size(), 0);

    for (int i = 0; i < 256; i++) begin
      send_frame(8'h01, 32'h30, i, 1'b1);
      if (i == 253) chk("sat_fe", err_cnt, 8'hFE);
      if (i == 254) chk("sat_ff", err_cnt, 8'hFF);
    end
    chk("sat_hold_ff", err_cnt, 8'hFF);

    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rst_sat_err", err_cnt, 0);

    raw = '{8'h55, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02};
    foreach (raw[i]) send_byte(raw[i]);
    chk("run_boot_done", boot_done, 1);
    chk("run_we", bus.mem_we, 0);
    raw = '{8'h55, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h33,
            8'h55, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4F};
    foreach (raw[i]) begin
      @(negedge clk);
      chk($sformatf("drain_ready%0d", i), bus.rx_data_ready, 1);
      send_byte(raw[i]);
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_we", bus.mem_we, 0);
    chk("drain_boot_done", boot_done, 1);
    chk("drain_err", err_cnt, 0);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
